vga_scandoubler: RTL and testbench

VGA_SCANDOUBLER -- requirements
Module: vga_scandoubler

---
 rtl/vga_scandoubler_pkg.sv | 39 +++
 rtl/scandbl_linebuf.sv | 22 ++
 rtl/vga_scandoubler.sv | 178 +++++++++++++++++
 tb/tb_vga_scandoubler.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/vga_scandoubler_pkg.sv
// rtl/vga_scandoubler_pkg.sv - shared video constants, pixel packing and read-side states
package vga_scandoubler_pkg;

  localparam int HS_LEN_DEF    = 54;
  localparam int BLANK_LEN_DEF = 120;
  localparam int VS_MIN_DEF    = 200;
  localparam int VS_HOLD_DEF   = 640;
  localparam int HMIN_DEF      = 600;
  localparam int HTIMEOUT_DEF  = 1100;

  localparam int LINE_AW = 9;
  localparam int LB_AW   = LINE_AW + 1;

  typedef logic [8:0] pixel_t;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_PASS0,
    RD_PASS1
  } rd_state_t;

  function automatic pixel_t pack_pixel(input logic [2:0] r, input logic [2:0] g,
                                        input logic [2:0] b);
    return {g, r, b};
  endfunction

  function automatic logic [2:0] pix_g(input pixel_t p);
    return p[8:6];
  endfunction

  function automatic logic [2:0] pix_r(input pixel_t p);
    return p[5:3];
  endfunction

  function automatic logic [2:0] pix_b(input pixel_t p);
    return p[2:0];
  endfunction

endpackage

// File: rtl/scandbl_linebuf.sv
// rtl/scandbl_linebuf.sv - two-bank 1024x9 simple dual-port line store, bank in address MSB
module scandbl_linebuf
  import vga_scandoubler_pkg::*;
(
  input  logic             clk,
  input  logic             we,
  input  logic [LB_AW-1:0] waddr,
  input  pixel_t           wdata,
  input  logic [LB_AW-1:0] raddr,
  output pixel_t           rdata
);

  pixel_t mem [0:(1 << LB_AW) - 1];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/vga_scandoubler.sv
// rtl/vga_scandoubler.sv - 15 kHz to 31 kHz line doubler with csync separation
module vga_scandoubler
  import vga_scandoubler_pkg::*;
#(
  parameter int HS_LEN    = HS_LEN_DEF,
  parameter int BLANK_LEN = BLANK_LEN_DEF,
  parameter int VS_MIN    = VS_MIN_DEF,
  parameter int VS_HOLD   = VS_HOLD_DEF,
  parameter int HMIN      = HMIN_DEF,
  parameter int HTIMEOUT  = HTIMEOUT_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ce_in,
  input  logic [2:0] r_in,
  input  logic [2:0] g_in,
  input  logic [2:0] b_in,
  input  logic       csync_n_in,
  output logic [2:0] r_out,
  output logic [2:0] g_out,
  output logic [2:0] b_out,
  output logic       hsync_n_out,
  output logic       vsync_n_out
);

  logic         csync_d;
  logic [9:0]   low_cnt;
  logic [9:0]   vs_timer;
  logic [10:0]  hcnt;
  logic         fall;
  logic         line_start;

  logic               wr_bank;
  logic [LINE_AW-1:0] wr_addr;
  logic [LINE_AW-1:0] prev_len;
  logic [LINE_AW-1:0] line_len;
  logic [LB_AW-1:0]   waddr;

  rd_state_t          rd_state, rd_state_nx;
  logic [LINE_AW-1:0] rd_addr, rd_addr_nx;
  logic               rd_bank;
  logic               rd_last;
  logic               rd_active;

  pixel_t rdata;
  logic   hs_p;
  logic   vis_p;

  // hcnt holds cycles since the last start minus one, so spacing >= HMIN means hcnt >= HMIN-1
  assign fall       = csync_d & ~csync_n_in;
  assign line_start = (fall && (hcnt >= 11'(HMIN - 1))) || (hcnt == 11'(HTIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csync_d     <= 1'b1;
      low_cnt     <= '0;
      vs_timer    <= '0;
      vsync_n_out <= 1'b1;
      hcnt        <= '0;
    end else begin
      csync_d <= csync_n_in;
      if (csync_n_in) begin
        low_cnt <= '0;
      end else if (low_cnt != '1) begin
        low_cnt <= low_cnt + 10'd1;
      end
      if (low_cnt == 10'(VS_MIN)) begin
        vs_timer    <= 10'(VS_HOLD);
        vsync_n_out <= 1'b0;
      end else if (vs_timer != '0) begin
        vs_timer <= vs_timer - 10'd1;
        if (vs_timer == 10'd1) begin
          vsync_n_out <= 1'b1;
        end
      end
      hcnt <= line_start ? '0 : hcnt + 11'd1;
    end
  end

  assign line_len = (wr_addr == '0) ? 9'd1 : wr_addr;
  // A pixel coinciding with a line start belongs to the new line, at address 0 of the new bank
  assign waddr    = line_start ? {~wr_bank, 9'd0} : {wr_bank, wr_addr};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_bank  <= 1'b0;
      wr_addr  <= '0;
      prev_len <= '0;
    end else if (line_start) begin
      prev_len <= line_len;
      wr_bank  <= ~wr_bank;
      wr_addr  <= {8'd0, ce_in};
    end else if (ce_in && (wr_addr != '1)) begin
      wr_addr <= wr_addr + 9'd1;
    end
  end

  scandbl_linebuf u_linebuf (
    .clk   (clk),
    .we    (ce_in),
    .waddr (waddr),
    .wdata (pack_pixel(r_in, g_in, b_in)),
    .raddr ({rd_bank, rd_addr}),
    .rdata (rdata)
  );

  assign rd_last   = (rd_addr == (prev_len - 9'd1));
  assign rd_active = (rd_state != RD_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_state <= RD_IDLE;
      rd_addr  <= '0;
      rd_bank  <= 1'b0;
    end else begin
      rd_state <= rd_state_nx;
      rd_addr  <= rd_addr_nx;
      if (line_start) begin
        rd_bank <= wr_bank;
      end
    end
  end

  always_comb begin
    rd_state_nx = rd_state;
    rd_addr_nx  = rd_addr;
    if (line_start) begin
      rd_state_nx = RD_PASS0;
      rd_addr_nx  = '0;
    end else begin
      case (rd_state)
        RD_PASS0: begin
          if (rd_last) begin
            rd_state_nx = RD_PASS1;
            rd_addr_nx  = '0;
          end else begin
            rd_addr_nx = rd_addr + 9'd1;
          end
        end
        RD_PASS1: begin
          if (rd_last) begin
            rd_state_nx = RD_IDLE;
          end else begin
            rd_addr_nx = rd_addr + 9'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Flags travel alongside the RAM read so sync and colour leave with equal latency
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_p        <= 1'b0;
      vis_p       <= 1'b0;
      hsync_n_out <= 1'b1;
      r_out       <= '0;
      g_out       <= '0;
      b_out       <= '0;
    end else begin
      hs_p        <= rd_active && (rd_addr < 9'(HS_LEN));
      vis_p       <= rd_active && (rd_addr >= 9'(BLANK_LEN));
      hsync_n_out <= ~hs_p;
      if (vis_p && vsync_n_out) begin
        r_out <= pix_r(rdata);
        g_out <= pix_g(rdata);
        b_out <= pix_b(rdata);
      end else begin
        r_out <= '0;
        g_out <= '0;
        b_out <= '0;
      end
    end
  end

endmodule

// File: tb/tb_vga_scandoubler.sv
// tb/tb_vga_scandoubler.sv - randomized bench for vga_scandoubler against a timeline model
module tb_vga_scandoubler;
  import vga_scandoubler_pkg::*;

  localparam int MAXC = 45000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ce_in = 1'b0;
  logic [2:0] r_in = '0, g_in = '0, b_in = '0;
  logic       csync_n_in = 1'b1;
  logic [2:0] r_out, g_out, b_out;
  logic       hsync_n_out, vsync_n_out;

  int vectors = 0;
  int miscompares = 0;

  vga_scandoubler dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ce_in       (ce_in),
    .r_in        (r_in),
    .g_in        (g_in),
    .b_in        (b_in),
    .csync_n_in  (csync_n_in),
    .r_out       (r_out),
    .g_out       (g_out),
    .b_out       (b_out),
    .hsync_n_out (hsync_n_out),
    .vsync_n_out (vsync_n_out)
  );

  always #35 clk = ~clk;

  // Timeline model: per output edge, where the read pass stands and what vsync is
  bit         rst_at   [MAXC];
  bit         act_at   [MAXC];
  int         addr_at  [MAXC];
  bit         vs_at    [MAXC];
  logic [8:0] pix_at   [MAXC];
  bit         pknown_at[MAXC];

  logic [8:0] line_mem [2][512];
  bit         line_known [2][512];

  int n = 0;
  bit phase = 1'b0;
  int last_start, low_since, last_det, wbank, wcount, rd_start, rd_len, rd_bank;
  bit prev_cs, rd_valid;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s edge=%0d got=%0h exp=%0h", tag, n, got, exp);
    end
  endtask

  task automatic model_edge();
    bit fall, start;
    int a, e;
    if (!rst_n) begin
      rst_at[n] = 1'b1;
      last_start = n;
      prev_cs = 1'b1;
      low_since = -1;
      last_det = -1000000;
      wbank = 0;
      wcount = 0;
      rd_valid = 1'b0;
      act_at[n] = 1'b0;
      addr_at[n] = 0;
      vs_at[n] = 1'b1;
      pknown_at[n] = 1'b0;
      pix_at[n] = '0;
      return;
    end
    rst_at[n] = 1'b0;
    if (n > 0 && act_at[n-1]) begin
      pix_at[n] = line_mem[rd_bank][addr_at[n-1]];
      pknown_at[n] = line_known[rd_bank][addr_at[n-1]];
    end else begin
      pix_at[n] = '0;
      pknown_at[n] = 1'b0;
    end
    if (low_since >= 0 && (n - low_since) == VS_MIN_DEF) last_det = n;
    if (csync_n_in) low_since = -1;
    else if (low_since < 0) low_since = n;
    fall = prev_cs && !csync_n_in;
    prev_cs = csync_n_in;
    start = (fall && (n - last_start) >= HMIN_DEF) || ((n - last_start) == HTIMEOUT_DEF);
    if (start) begin
      rd_len = (wcount > 511) ? 511 : wcount;
      if (rd_len == 0) rd_len = 1;
      rd_bank = wbank;
      wbank ^= 1;
      wcount = 0;
      rd_valid = 1'b1;
      rd_start = n;
      last_start = n;
    end
    if (ce_in) begin
      a = (wcount > 511) ? 511 : wcount;
      line_mem[wbank][a] = {g_in, r_in, b_in};
      line_known[wbank][a] = 1'b1;
      wcount++;
    end
    e = n - rd_start;
    if (rd_valid && e < 2 * rd_len) begin
      act_at[n] = 1'b1;
      addr_at[n] = e % rd_len;
    end else begin
      act_at[n] = 1'b0;
      addr_at[n] = 0;
    end
    vs_at[n] = !((n - last_det) < VS_HOLD_DEF);
  endtask

  task automatic compare_edge();
    bit exp_hs, vis;
    logic [8:0] exp_rgb;
    if (n < 2) return;
    if (rst_at[n] || rst_at[n-1]) begin
      exp_hs = 1'b1;
      vis = 1'b0;
    end else begin
      exp_hs = !(act_at[n-2] && addr_at[n-2] < HS_LEN_DEF);
      vis = act_at[n-2] && addr_at[n-2] >= BLANK_LEN_DEF && vs_at[n-1];
    end
    exp_rgb = vis ? pix_at[n-1] : 9'd0;
    check_val("hsync", hsync_n_out, exp_hs);
    check_val("vsync", vsync_n_out, vs_at[n]);
    if (!vis || pknown_at[n-1]) check_val("rgb", {g_out, r_out, b_out}, exp_rgb);
  endtask

  task automatic cycle(input bit rst_v, input bit cs_v);
    rst_n = rst_v;
    csync_n_in = cs_v;
    ce_in = phase;
    phase = ~phase;
    r_in = 3'($urandom);
    g_in = 3'($urandom);
    b_in = 3'($urandom);
    model_edge();
    @(posedge clk);
    @(negedge clk);
    compare_edge();
    n++;
  endtask

  task automatic send(input int spacing, input int low_len);
    for (int i = 0; i < spacing; i++) cycle(1'b1, i >= low_len);
  endtask

  initial begin
    @(negedge clk);
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1);
    send(700, 0);
    for (int i = 0; i < 6; i++) send(896, 33);
    for (int i = 0; i < 6; i++) send(448, $urandom_range(12, 20));
    for (int i = 0; i < 5; i++) send(448, 380);
    for (int i = 0; i < 4; i++) send(448, 16);
    for (int i = 0; i < 4; i++) send(896, 33);
    send(600, 10);
    send(599, 10);
    send(601, 10);
    send(896, 33);
    for (int i = 0; i < 8; i++) send($urandom_range(560, 1150), $urandom_range(4, 40));
    send(896, 33);
    send(3000, 0);
    for (int i = 0; i < 3; i++) send(896, 33);
    send(400, 33);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1);
    send(700, 0);
    for (int i = 0; i < 3; i++) send(896, 33);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
